// File: rtl/rx_cmd_parser_pkg.sv
// rtl/rx_cmd_parser_pkg.sv - shared constants, command strings and FSM state type
package rx_cmd_parser_pkg;

    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_NINE   = 8'h39;
    localparam logic [7:0] RATE_DEFAULT = 8'h31;

    localparam int MAX_LEN_DEFAULT = 8;

    // Command strings are left-aligned: character i sits at bits [8*(STR_W-i)-1 -: 8].
    localparam int                 STR_W      = 6;
    localparam logic [8*STR_W-1:0] STR_INIT   = {"init", 16'h0000};
    localparam logic [8*STR_W-1:0] STR_NORMAL = "normal";
    localparam logic [8*STR_W-1:0] STR_START  = {"start", 8'h00};
    localparam logic [8*STR_W-1:0] STR_RATE   = {"rate", ASCII_COLON, 8'h00};
    localparam logic [3:0]         LEN_INIT   = 4'd4;
    localparam logic [3:0]         LEN_NORMAL = 4'd6;
    localparam logic [3:0]         LEN_START  = 4'd5;
    localparam logic [3:0]         LEN_RATE_PREFIX = 4'd5;
    localparam logic [3:0]         LEN_RATE   = 4'd6;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/rx_line_buffer.sv
// rtl/rx_line_buffer.sv - byte storage for one command line with length counter and full flag
module rx_line_buffer #(
    parameter int MAX_LEN = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    clr,
    input  logic [7:0]              data,
    output logic [MAX_LEN-1:0][7:0] line,
    output logic [3:0]              len,
    output logic                    full
);

    // Contents need no reset; only len decides which bytes are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (wr && (len == 4'(i))) begin
                line[i] <= data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= 4'd0;
        end else if (clr) begin
            len <= 4'd0;
        end else if (wr) begin
            len <= len + 4'd1;
        end
    end

    assign full = (len == 4'(MAX_LEN));

endmodule

// File: rtl/rx_cmd_parser.sv
// rtl/rx_cmd_parser.sv - line-oriented ASCII command decoder fed by a UART receiver
module rx_cmd_parser #(
    parameter int MAX_LEN = rx_cmd_parser_pkg::MAX_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iRX_DATA,
    input  logic       iRX_VALID,
    output logic       oCMD_INIT,
    output logic       oCMD_NORMAL,
    output logic       oCMD_START,
    output logic [7:0] oRATE,
    output logic       oRATE_VALID,
    output logic       oERR,
    output logic       oBUSY
);
    import rx_cmd_parser_pkg::*;

    state_t                   state, next_state;
    logic [MAX_LEN-1:0][7:0]  line;
    logic [3:0]               len;
    logic                     full, buf_wr, buf_clr;
    logic                     nxt_init, nxt_normal, nxt_start, nxt_rate_valid, nxt_err;
    logic [7:0]               nxt_rate;

    rx_line_buffer #(.MAX_LEN(MAX_LEN)) u_line_buffer (
        .clk   (clk),
        .reset (reset),
        .wr    (buf_wr),
        .clr   (buf_clr),
        .data  (iRX_DATA),
        .line  (line),
        .len   (len),
        .full  (full)
    );

    function automatic logic prefix_is(input logic [MAX_LEN-1:0][7:0] l,
                                       input logic [8*STR_W-1:0]     s,
                                       input logic [3:0]             n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < STR_W; i++) begin
            if ((4'(i) < n) && (l[i] != s[8*(STR_W-i)-1 -: 8])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        buf_wr         = 1'b0;
        buf_clr        = 1'b0;
        nxt_init       = 1'b0;
        nxt_normal     = 1'b0;
        nxt_start      = 1'b0;
        nxt_rate_valid = 1'b0;
        nxt_err        = 1'b0;
        nxt_rate       = oRATE;
        if (iRX_VALID) begin
            case (state)
                ST_COLLECT: begin
                    if (iRX_DATA == ASCII_LF) begin
                        buf_clr = 1'b1;
                        if (len == LEN_INIT && prefix_is(line, STR_INIT, LEN_INIT)) begin
                            nxt_init = 1'b1;
                        end else if (len == LEN_NORMAL && prefix_is(line, STR_NORMAL, LEN_NORMAL)) begin
                            nxt_normal = 1'b1;
                        end else if (len == LEN_START && prefix_is(line, STR_START, LEN_START)) begin
                            nxt_start = 1'b1;
                        end else if (len == LEN_RATE && prefix_is(line, STR_RATE, LEN_RATE_PREFIX)
                                     && is_digit(line[5])) begin
                            nxt_rate_valid = 1'b1;
                            nxt_rate       = line[5];
                        end else if (len != 4'd0) begin
                            nxt_err = 1'b1;
                        end
                    end else if (iRX_DATA != ASCII_CR) begin
                        if (full) begin
                            next_state = ST_DISCARD;
                            buf_clr    = 1'b1;
                        end else begin
                            buf_wr = 1'b1;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (iRX_DATA == ASCII_LF) begin
                        nxt_err    = 1'b1;
                        next_state = ST_COLLECT;
                    end
                end
                default: next_state = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oCMD_INIT   <= 1'b0;
            oCMD_NORMAL <= 1'b0;
            oCMD_START  <= 1'b0;
            oRATE_VALID <= 1'b0;
            oERR        <= 1'b0;
            oRATE       <= RATE_DEFAULT;
        end else begin
            oCMD_INIT   <= nxt_init;
            oCMD_NORMAL <= nxt_normal;
            oCMD_START  <= nxt_start;
            oRATE_VALID <= nxt_rate_valid;
            oERR        <= nxt_err;
            oRATE       <= nxt_rate;
        end
    end

    assign oBUSY = (len != 4'd0) || (state == ST_DISCARD);

endmodule
